// File: rtl/apb_sram_pkg.sv
// Shared definitions for the APB SRAM arbiter: FSM encoding, bus width defaults,
// timeout counter width and the round-robin pointer step.
package apb_sram_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 32;
    localparam int TO_CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The client after the one just served becomes highest priority.
    function automatic int next_rr(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/apb_sram_arb_if.sv
// APB bus between the arbiter (master) and the apb_sram slave port.
interface apb_sram_arb_if
    import apb_sram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata
    );

endinterface

// File: rtl/apb_sram_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward and wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            valid
);

    int idx;

    always_comb begin
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_sram_arb.sv
// Round-robin APB master front-end sharing one apb_sram slave between NREQ
// req/ack clients, with a pready timeout reported as rsp_err.
module apb_sram_arb
    import apb_sram_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ack,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    apb_sram_arb_if.master    apb
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);

    logic [1:0]          state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      cur_id;
    logic [NREQ-1:0]     cur_oh;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [TO_CNT_W-1:0] to_next;
    logic                timed_out;

    logic [NREQ-1:0]     gnt_oh;
    logic [IDW-1:0]      gnt_id;
    logic                gnt_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr),
        .grant (gnt_oh),
        .id    (gnt_id),
        .valid (gnt_valid)
    );

    // pready arriving in the same cycle the limit is hit still counts as success.
    assign to_next   = to_cnt + 1'b1;
    assign timed_out = (TIMEOUT_CYC != 0) && (to_next == TO_LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cur_id      <= '0;
            cur_oh      <= '0;
            to_cnt      <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.paddr   <= '0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= '0;
            req_ack     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        cur_id     <= gnt_id;
                        cur_oh     <= gnt_oh;
                        apb.paddr  <= req_addr[int'(gnt_id)*AW +: AW];
                        apb.pwrite <= req_write[gnt_id];
                        apb.pwdata <= req_wdata[int'(gnt_id)*DW +: DW];
                        apb.psel   <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    to_cnt <= to_next;
                    if (apb.pready || timed_out) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        req_ack     <= cur_oh;
                        rsp_err     <= !apb.pready;
                        rsp_rdata   <= (apb.pready && !apb.pwrite) ? apb.prdata : '0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No arbitration here, so the just-acked client's stale req is skipped.
                    req_ack   <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    to_cnt    <= '0;
                    ptr       <= IDW'(next_rr(int'(cur_id), NREQ));
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_arb.sv
// Directed bench for apb_sram_arb with a small apb_sram slave model and an
// expected-response scoreboard checked on every req_ack.
module tb_apb_sram_arb;

    localparam int NREQ = 2;
    localparam int AW   = 12;
    localparam int DW   = 32;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ack;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;

    apb_sram_arb_if #(.AW(AW), .DW(DW)) apb ();

    apb_sram_arb #(
        .NREQ        (NREQ),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 clk = ~clk;

    // Slave model: 1024-word memory, programmable wait states, optional stuck pready.
    logic [31:0] mem [1024];
    int          slave_waits = 0;
    int          wait_left = 0;
    logic        stuck = 1'b0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_val;
        else if (apb.psel && apb.penable && apb.pready && apb.pwrite)
            mem[apb.paddr[11:2]] <= apb.pwdata;
        if (apb.psel && !apb.penable)
            wait_left <= slave_waits;
        else if (apb.psel && apb.penable && wait_left != 0)
            wait_left <= wait_left - 1;
    end

    assign apb.pready = apb.psel && apb.penable && (wait_left == 0) && !stuck;
    assign apb.prdata = mem[apb.paddr[11:2]];

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_val = val;
        @(negedge clk);
        bd_we  = 1'b0;
    endtask

    task automatic checkAck();
        exp_t e;
        checkOutput("sb_nonempty", 64'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("ack_id", req_ack, 64'(1) << e.id);
            checkOutput("ack_rdata", rsp_rdata, e.rdata);
            checkOutput("ack_err", rsp_err, e.err);
        end
        checkOutput("ack_psel", apb.psel, 0);
        checkOutput("ack_penable", apb.penable, 0);
    endtask

    // One transfer from an idle bus: drive, watch the APB phases, then check the ack.
    task automatic applyStimulus(input int id, input logic wr, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat);
        int lat;
        bit done;
        @(negedge clk);
        sb_q.push_back('{id, exp_rdata, exp_err});
        req[id]                = 1'b1;
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (req_ack != '0) begin
                done = 1'b1;
            end else begin
                checkOutput("psel", apb.psel, 1);
                checkOutput("penable", apb.penable, 64'(lat > 1));
                checkOutput("paddr", apb.paddr, addr);
                checkOutput("pwrite", apb.pwrite, wr);
                if (wr) checkOutput("pwdata", apb.pwdata, wdata);
            end
        end
        req[id] = 1'b0;
        checkOutput("ack_latency", lat, exp_lat);
        if (done) checkAck();
    endtask

    initial begin
        int gap;
        int nack;

        #1;
        $display("[TB] reset values");
        checkOutput("rst_psel", apb.psel, 0);
        checkOutput("rst_penable", apb.penable, 0);
        checkOutput("rst_paddr", apb.paddr, 0);
        checkOutput("rst_ack", req_ack, 0);
        checkOutput("rst_rdata", rsp_rdata, 0);
        checkOutput("rst_err", rsp_err, 0);
        preload(10'd1023, 32'h12345678);
        preload(10'd0,    32'hCAFE0000);
        preload(10'd8,    32'h88880008);
        preload(10'd3,    32'h33333333);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] single write");
        applyStimulus(0, 1'b1, 12'h004, 32'hA5A50001, 32'h0, 1'b0, 3);
        checkOutput("mem_w1", mem[1], 32'hA5A50001);

        $display("[TB] boundary reads");
        applyStimulus(1, 1'b0, 12'hFFC, 32'h0, 32'h12345678, 1'b0, 3);
        applyStimulus(0, 1'b0, 12'h000, 32'h0, 32'hCAFE0000, 1'b0, 3);

        $display("[TB] wait states");
        slave_waits = 3;
        applyStimulus(1, 1'b1, 12'h008, 32'h0BADF00D, 32'h0, 1'b0, 6);
        slave_waits = 0;
        checkOutput("mem_w2", mem[2], 32'h0BADF00D);

        $display("[TB] timeout");
        stuck = 1'b1;
        applyStimulus(0, 1'b0, 12'h004, 32'h0, 32'h0, 1'b1, 10);
        stuck = 1'b0;
        applyStimulus(0, 1'b0, 12'h004, 32'h0, 32'hA5A50001, 1'b0, 3);

        $display("[TB] reset during access");
        @(negedge clk);
        slave_waits       = 5;
        req[0]            = 1'b1;
        req_write[0]      = 1'b1;
        req_addr[0 +: AW] = 12'h00C;
        req_wdata[0 +: DW] = 32'hDEAD0003;
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_penable", apb.penable, 1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_psel", apb.psel, 0);
        checkOutput("rst_mid_penable", apb.penable, 0);
        checkOutput("rst_mid_ack", req_ack, 0);
        req_wdata[0 +: DW]  = 32'h11112222;
        req_write[1]        = 1'b0;
        req_addr[AW +: AW]  = 12'h020;
        req                 = 2'b11;
        slave_waits         = 0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_hold_ack", req_ack, 0);
            checkOutput("rst_hold_psel", apb.psel, 0);
        end
        checkOutput("aborted_no_write", mem[3], 32'h33333333);

        $display("[TB] contention after reset");
        sb_q.push_back('{0, 32'h0, 1'b0});
        sb_q.push_back('{1, 32'h88880008, 1'b0});
        sb_q.push_back('{0, 32'h0, 1'b0});
        sb_q.push_back('{1, 32'h88880008, 1'b0});
        rstn = 1'b1;
        gap  = 0;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge clk);
            gap++;
            if (req_ack != '0) begin
                checkOutput("ack_onehot", 64'($countones(req_ack)), 1);
                checkOutput("ack_gap", gap, (nack == 0) ? 3 : 4);
                checkAck();
                nack++;
                gap = 0;
                if (nack == 4) req = '0;
            end
        end
        req = '0;
        checkOutput("contention_acks", nack, 4);
        checkOutput("mem_w3", mem[3], 32'h11112222);
        repeat (3) @(negedge clk);
        checkOutput("idle_ack", req_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_sram_arb.md
Name: apb_sram_arb

Overview:
Two-requester APB master front-end that shares one apb_sram slave (the sp_sram wrapper) between internal clients. Each client presents a simple req/ack transfer request. The block arbitrates round-robin and sequences the APB SETUP/ACCESS phases. It returns read data or an error (pready timeout) to the granted client. It sits between client logic and the apb_sram slave port.

Parameters:
NREQ, 2, number of requesters (2..4 supported)
AW, 12, APB address width (byte address, word-aligned, bits [1:0] driven as issued)
DW, 32, data width
TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready; 0 disables timeout

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
req  in  NREQ  per-client request; held with fields stable until req_ack
req_write  in  NREQ  per-client 1=write, 0=read
req_addr  in  NREQ*AW  per-client address, client i at [i*AW +: AW]
req_wdata  in  NREQ*DW  per-client write data, client i at [i*DW +: DW]
req_ack  out  NREQ  one-cycle completion pulse to granted client
rsp_rdata  out  DW  read data, valid only while req_ack pulses (0 for writes/errors)
rsp_err  out  1  timeout error, valid with req_ack
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  AW  APB address
pwrite  out  1  APB direction
pwdata  out  DW  APB write data
pready  in  1  APB ready from apb_sram
prdata  in  DW  APB read data from apb_sram

Behaviour:
- Reset (async, rstn=0): all outputs 0, state IDLE, round-robin pointer 0 (client 0 highest priority), timeout counter 0. Takes effect immediately, including mid-transfer; the aborted transfer is never acked.
- All outputs registered; no combinational path from inputs to outputs.
- FSM states are IDLE, SETUP, ACCESS, DONE.
- IDLE, no req: stay in IDLE; psel=0, penable=0.
- IDLE, any req high: grant the first requesting client starting at the pointer, wrapping modulo NREQ. Latch id, addr, write, wdata onto paddr/pwrite/pwdata. Go to SETUP.
- SETUP (1 cycle): psel=1, penable=0. Go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable. The timeout counter increments each ACCESS cycle.
- ACCESS, pready=1: capture prdata if read. Go to DONE.
- ACCESS, pready=0 and counter reaches TIMEOUT_CYC (nonzero): set error flag. Go to DONE.
- DONE (1 cycle): psel=0, penable=0; req_ack[id]=1; rsp_rdata=captured data (read, no error) else 0; rsp_err=error flag. Pointer moves to (id+1) mod NREQ. Counter clears. Go to IDLE. No arbitration happens in DONE, so the acked client's stale req is never re-sampled.
- Client contract: after sampling req_ack, a client either drops req or presents a new request the next cycle. A held req is treated as a new transfer.
- Latency, zero-wait slave: req seen at cycle 0; psel at cycle 1; penable at cycle 2; ack at cycle 3. Each wait state adds 1. Peak throughput is 1 transfer per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE. Losers wait with no starvation; the worst-case wait is NREQ-1 transfers.
- req changing while not granted is allowed. req dropping while granted is a contract violation; the transfer still completes.
- Timeout window: pready high in the same cycle the counter hits TIMEOUT_CYC counts as success.
- Boundaries: address wrap is not the block's concern; paddr is passed through unmodified, e.g. 0xFFC maps to word 1023.

Decomposition:
- Package apb_sram_pkg holds the state encoding (IDLE/SETUP/ACCESS/DONE), the AW/DW defaults and the timeout counter width.
- Sub-module rr_arbiter: inputs req vector and pointer; outputs one-hot grant and encoded id. Purely combinational and reusable.
- apb_sram_arb holds the FSM, data registers and pointer.

Test Plan:
- Single write: client0 writes addr 0x004, data 0xA5A50001, pready tied 1. Required: psel at cycle 1, penable at cycle 2, req_ack[0] at cycle 3, rsp_err=0, and sram word 1 = 0xA5A50001.
- Boundary read: preload word 1023 = 0x12345678; client1 reads 0xFFC. Required: req_ack[1] with rsp_rdata=0x12345678. Reading 0x000 returns word 0.
- Contention: after reset, req0 and req1 both high with continuous back-to-back requests. Required: grant order 0,1,0,1; acks never overlap; no client gets two acks in a row while the other waits.
- Wait states: slave holds pready=0 for 3 ACCESS cycles. Required: psel/penable/paddr/pwdata stable throughout; ack exactly one cycle after pready=1 is sampled; total 6 cycles.
- Timeout: TIMEOUT_CYC=8, pready stuck 0, client0 read. Required: ack after 8 ACCESS cycles with rsp_err=1 and rsp_rdata=0; next transfer proceeds normally.
- Reset mid-ACCESS: drop rstn for 2 cycles during a wait-stated write. Required: psel/penable/req_ack go 0 immediately, no ack for the aborted transfer, and after release client0 is granted first.
